// File: rtl/load_store_unit_if.sv
// Request/response bus between the control unit and load_store_unit.
// The master issues valid/ready requests; the slave returns one-cycle response pulses.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, misalign
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory stage: byte/half/word loads and stores against a 2^ADDR_W x 32 synchronous RAM.
// Define MISALIGN_TRAP_EN to drop misaligned requests with a misalign response instead of aligning them.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t              state_r;
  logic                ready_r;
  logic                rsp_valid_r;
  logic [31:0]         rsp_rdata_r;
  logic                misalign_r;
  logic [1:0]          size_r;
  logic                signed_r;
  logic [1:0]          off_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [31:0]         ram_q_r;
  logic [31:0]         mem [0:DEPTH-1];

  logic                accept_s;
  logic                trap_s;
  logic                wr_en_s;
  logic [1:0]          off_s;
  logic [3:0]          wr_be_s;
  logic [31:0]         wr_data_s;
  logic [ADDR_W-1:0]   wr_idx_s;
  logic [7:0]          byte_s;
  logic [15:0]         half_s;
  logic [31:0]         load_ext_s;
  logic                unused_s;

  assign accept_s = bus.req_valid & ready_r & ~reset;
  assign wr_idx_s = bus.req_addr[ADDR_W+1:2];
  assign wr_en_s  = accept_s & bus.req_we & ~trap_s;
  assign unused_s = ^{1'b0, bus.req_addr[31:ADDR_W+2]};

`ifdef MISALIGN_TRAP_EN
  logic mis_s;
  assign mis_s  = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                  (bus.req_size[1] & (bus.req_addr[1:0] != 2'b00));
  assign trap_s = mis_s;
`else
  assign trap_s = 1'b0;
`endif

  // Aligned byte offset of the request; half and word force the low bits clear.
  always_comb begin
    off_s = 2'b00;
    case (bus.req_size)
      2'b00:   off_s = bus.req_addr[1:0];
      2'b01:   off_s = {bus.req_addr[1], 1'b0};
      default: off_s = 2'b00;
    endcase
  end

  // Store lane enables and replicated write data.
  always_comb begin
    wr_be_s   = 4'b0000;
    wr_data_s = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        wr_be_s   = 4'b0001 << off_s;
        wr_data_s = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be_s   = off_s[1] ? 4'b1100 : 4'b0011;
        wr_data_s = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        wr_be_s   = 4'b1111;
        wr_data_s = bus.req_wdata;
      end
    endcase
  end

  // RAM array: byte-enabled write on the accept edge, registered read during RD; never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (wr_be_s[0]) mem[wr_idx_s][7:0]   <= wr_data_s[7:0];
      if (wr_be_s[1]) mem[wr_idx_s][15:8]  <= wr_data_s[15:8];
      if (wr_be_s[2]) mem[wr_idx_s][23:16] <= wr_data_s[23:16];
      if (wr_be_s[3]) mem[wr_idx_s][31:24] <= wr_data_s[31:24];
    end
    if (state_r == RD) begin
      ram_q_r <= mem[idx_r];
    end
  end

  // Lane/half selection and sign or zero extension of the registered RAM word.
  always_comb begin
    byte_s     = 8'h00;
    half_s     = 16'h0000;
    load_ext_s = ram_q_r;
    case (off_r)
      2'b00:   byte_s = ram_q_r[7:0];
      2'b01:   byte_s = ram_q_r[15:8];
      2'b10:   byte_s = ram_q_r[23:16];
      default: byte_s = ram_q_r[31:24];
    endcase
    half_s = off_r[1] ? ram_q_r[31:16] : ram_q_r[15:0];
    case (size_r)
      2'b00:   load_ext_s = {{24{signed_r & byte_s[7]}}, byte_s};
      2'b01:   load_ext_s = {{16{signed_r & half_s[15]}}, half_s};
      default: load_ext_s = ram_q_r;
    endcase
  end

  // Control FSM with registered ready and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      misalign_r  <= 1'b0;
      size_r      <= 2'b00;
      signed_r    <= 1'b0;
      off_r       <= 2'b00;
      idx_r       <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      misalign_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            size_r   <= bus.req_size;
            signed_r <= bus.req_signed;
            off_r    <= off_s;
            idx_r    <= wr_idx_s;
            ready_r  <= 1'b0;
            if (trap_s) begin
              state_r     <= ACK;
              rsp_valid_r <= 1'b1;
              misalign_r  <= 1'b1;
            end else if (bus.req_we) begin
              state_r     <= ACK;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r     <= RD;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        RD: begin
          state_r <= DATA;
          ready_r <= 1'b0;
        end
        DATA: begin
          state_r     <= IDLE;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= load_ext_s;
        end
        ACK: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.misalign  = misalign_r;

endmodule
